// File: rtl/ebi_pkg.sv
// rtl/ebi_pkg.sv - shared types and encodings for the EBI region adapter
package ebi_pkg;

  localparam logic [1:0] DW_ENC_32  = 2'b00;
  localparam logic [1:0] DW_ENC_16  = 2'b01;
  localparam logic [1:0] DW_ENC_8   = 2'b10;
  localparam logic [1:0] DW_ENC_RSV = 2'b11;

  typedef enum logic [1:0] {
    DW32 = 2'b00,
    DW16 = 2'b01,
    DW8  = 2'b10
  } dw_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_SUB  = 2'b10,
    ST_DONE = 2'b11
  } ebi_state_t;

  // The reserved width code falls back to a full 32-bit device.
  function automatic dw_t dw_decode(input logic [1:0] enc);
    case (enc)
      DW_ENC_16: return DW16;
      DW_ENC_8:  return DW8;
      default:   return DW32;
    endcase
  endfunction

endpackage

// File: rtl/ebi_region_adapter_if.sv
// rtl/ebi_region_adapter_if.sv - CPU-side bus-cycle signals of the EBI region adapter
interface ebi_region_adapter_if;

  logic [31:0] A;
  logic [3:0]  BEn;
  logic [1:0]  ST;
  logic        DAn;
  logic        MRQn;
  logic        RW;
  logic        BCYSTn;
  logic [31:0] D_I;
  logic [31:0] D_O;
  logic        READYn;
  logic        SZRQn;

  modport master (
    output A, BEn, ST, DAn, MRQn, RW, BCYSTn, D_I,
    input  D_O, READYn, SZRQn
  );

  modport slave (
    input  A, BEn, ST, DAn, MRQn, RW, BCYSTn, D_I,
    output D_O, READYn, SZRQn
  );

endinterface

// File: rtl/ebi_lane_steer.sv
// rtl/ebi_lane_steer.sv - byte-lane steering between the 32-bit CPU bus and narrow devices
module ebi_lane_steer
  import ebi_pkg::*;
(
  input  dw_t         dw,
  input  logic        a1,
  input  logic        boff,
  input  logic        two,
  input  logic [3:0]  ben,
  input  logic [31:0] di,
  input  logic [31:0] mem_do,
  input  logic [7:0]  cap,
  output logic [1:0]  mem_a_lo,
  output logic [3:0]  mem_nbe,
  output logic [31:0] mem_di,
  output logic [31:0] rd_data
);

  logic [15:0] di_half;
  logic [1:0]  ben_half;
  logic [7:0]  di_byte;

  always_comb begin
    di_half  = a1 ? di[31:16] : di[15:0];
    ben_half = a1 ? ben[3:2] : ben[1:0];
    di_byte  = boff ? di_half[15:8] : di_half[7:0];

    mem_a_lo = 2'b00;
    mem_nbe  = ben;
    mem_di   = di;
    rd_data  = mem_do;

    // Narrow devices return data on the low lanes; replicate so either CPU half sees it.
    case (dw)
      DW16: begin
        mem_a_lo = {a1, 1'b0};
        mem_nbe  = {2'b11, ben_half};
        mem_di   = {16'h0000, di_half};
        rd_data  = {2{mem_do[15:0]}};
      end
      DW8: begin
        mem_a_lo = {a1, boff};
        mem_nbe  = 4'b1110;
        mem_di   = {24'h000000, di_byte};
        rd_data  = two ? {2{mem_do[7:0], cap}} : {4{mem_do[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ebi_region_adapter.sv
// rtl/ebi_region_adapter.sv - decodes CPU bus cycles into per-region async device accesses
// with programmable wait states and 32/16/8-bit device widths.
module ebi_region_adapter
  import ebi_pkg::*;
#(
  parameter int                 NREG     = 2,
  parameter logic [NREG*32-1:0] REG_BASE = {32'h0000_0000, 32'h8000_0000},
  parameter logic [NREG*32-1:0] REG_MASK = {32'h8000_0000, 32'h8000_0000},
  parameter int                 MAXWS    = 15,
  localparam int                WSW      = $clog2(MAXWS + 1)
) (
  input  logic                  CLK,
  input  logic                  RESn,
  input  logic                  CE,
  ebi_region_adapter_if.slave   bus,
  input  logic [NREG*WSW-1:0]   CFG_WS,
  input  logic [NREG*2-1:0]     CFG_DW,
  output logic [NREG-1:0]       MEM_nCE,
  output logic [31:0]           MEM_A,
  output logic [3:0]            MEM_nBE,
  output logic                  MEM_nWE,
  output logic                  MEM_nOE,
  output logic [31:0]           MEM_DI,
  input  logic [31:0]           MEM_DO
);

  localparam int              IW     = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [WSW-1:0]  WS_MAX = WSW'(MAXWS);

  ebi_state_t     state_q, state_d;
  logic           hit_q, hit_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [WSW-1:0] ws_q, ws_d;
  logic [WSW-1:0] cnt_q, cnt_d;
  dw_t            dw_q, dw_d;
  logic [31:0]    a_q, a_d;
  logic [3:0]     ben_q, ben_d;
  logic           rw_q, rw_d;
  logic [31:0]    di_q, di_d;
  logic           two_q, two_d;
  logic           boff_q, boff_d;
  logic [7:0]     cap_q, cap_d;

  logic           dec_hit;
  logic [IW-1:0]  dec_idx;
  logic [WSW-1:0] dec_ws;
  logic [1:0]     dec_dw;
  logic [1:0]     start_hb;
  logic           start;
  logic           last_cnt;
  logic           ready_c;
  logic           busy;

  logic [1:0]     st_a_lo;
  logic [3:0]     st_nbe;
  logic [31:0]    st_di;
  logic [31:0]    st_rd;

  logic           unused_bits;
  assign unused_bits = ^{bus.ST, a_q[0]};

  // Descending scan so the lowest matching region index wins.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    dec_ws  = '0;
    dec_dw  = DW_ENC_32;
    for (int i = NREG - 1; i >= 0; i--) begin
      if ((bus.A & REG_MASK[i*32 +: 32]) == REG_BASE[i*32 +: 32]) begin
        dec_hit = 1'b1;
        dec_idx = IW'(i);
        dec_ws  = CFG_WS[i*WSW +: WSW];
        dec_dw  = CFG_DW[i*2 +: 2];
      end
    end
  end

  always_comb begin
    start_hb = bus.A[1] ? bus.BEn[3:2] : bus.BEn[1:0];
    start    = (state_q == ST_IDLE) && !bus.BCYSTn && !bus.MRQn && !bus.DAn;
    last_cnt = (cnt_q == ws_q);
    ready_c  = ((state_q == ST_WAIT) && (!hit_q || (last_cnt && !two_q))) ||
               ((state_q == ST_SUB) && last_cnt);
    busy     = ((state_q == ST_WAIT) || (state_q == ST_SUB)) && hit_q;
  end

  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    idx_d   = idx_q;
    ws_d    = ws_q;
    cnt_d   = cnt_q;
    dw_d    = dw_q;
    a_d     = a_q;
    ben_d   = ben_q;
    rw_d    = rw_q;
    di_d    = di_q;
    two_d   = two_q;
    boff_d  = boff_q;
    cap_d   = cap_q;

    if (CE) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_WAIT;
            hit_d   = dec_hit;
            idx_d   = dec_idx;
            ws_d    = (dec_ws > WS_MAX) ? WS_MAX : dec_ws;
            cnt_d   = '0;
            dw_d    = dw_decode(dec_dw);
            a_d     = bus.A;
            ben_d   = bus.BEn;
            rw_d    = bus.RW;
            di_d    = bus.D_I;
            two_d   = (dw_decode(dec_dw) == DW8) && (start_hb == 2'b00);
            // Only the upper byte enabled starts at offset 1; otherwise the lower byte.
            boff_d  = (start_hb == 2'b01);
            cap_d   = '0;
          end
        end
        ST_WAIT, ST_SUB: begin
          if (ready_c) begin
            state_d = ST_DONE;
          end else if (bus.DAn) begin
            state_d = ST_IDLE;
          end else if ((state_q == ST_WAIT) && last_cnt) begin
            state_d = ST_SUB;
            cnt_d   = '0;
            boff_d  = 1'b1;
            cap_d   = MEM_DO[7:0];
          end else begin
            cnt_d = (cnt_q == WS_MAX) ? cnt_q : cnt_q + WSW'(1);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      state_q <= ST_IDLE;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      ws_q    <= '0;
      cnt_q   <= '0;
      dw_q    <= DW32;
      a_q     <= '0;
      ben_q   <= 4'hF;
      rw_q    <= 1'b0;
      di_q    <= '0;
      two_q   <= 1'b0;
      boff_q  <= 1'b0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
      ws_q    <= ws_d;
      cnt_q   <= cnt_d;
      dw_q    <= dw_d;
      a_q     <= a_d;
      ben_q   <= ben_d;
      rw_q    <= rw_d;
      di_q    <= di_d;
      two_q   <= two_d;
      boff_q  <= boff_d;
      cap_q   <= cap_d;
    end
  end

  ebi_lane_steer u_steer (
    .dw       (dw_q),
    .a1       (a_q[1]),
    .boff     (boff_q),
    .two      (two_q),
    .ben      (ben_q),
    .di       (di_q),
    .mem_do   (MEM_DO),
    .cap      (cap_q),
    .mem_a_lo (st_a_lo),
    .mem_nbe  (st_nbe),
    .mem_di   (st_di),
    .rd_data  (st_rd)
  );

  // Every device-side output is a pure function of registered state, so CE low freezes them.
  always_comb begin
    MEM_nCE    = busy ? ~(NREG'(1) << idx_q) : '1;
    MEM_nOE    = ~(busy && rw_q);
    MEM_nWE    = ~(busy && !rw_q);
    MEM_A      = busy ? {a_q[31:2], st_a_lo} : '0;
    MEM_nBE    = busy ? st_nbe : 4'hF;
    MEM_DI     = (busy && !rw_q) ? st_di : '0;
    bus.READYn = ~ready_c;
    bus.SZRQn  = ~(ready_c && hit_q && (dw_q != DW32));
    bus.D_O    = (ready_c && hit_q && rw_q) ? st_rd : '0;
  end

endmodule
